// File: rtl/prog_loader_pkg.sv
// Shared widths and FSM state encodings for the run-time program loader.
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int CSUM_W     = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CSUM   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

endpackage

// File: rtl/prog_loader_ram.sv
// Program store: synchronous write, asynchronous read; contents survive reset.
module prog_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream (len_hi, len_lo, data..., checksum) into the program
// store and holds the processor in reset until a load completes with a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] program_byte,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] load_count
);

    // Length bits carried in the LEN_HI byte; the rest of that byte must be zero.
    localparam int HI_W = ADDR_W - DATA_W;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_load_count;
    logic [CSUM_W-1:0] r_sum;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_in_ready;
    logic              w_we;
    logic              w_xfer;
    logic              w_start_load;
    logic [ADDR_W-1:0] w_count_inc;
    logic [CSUM_W-1:0] w_sum_next;
    logic [ADDR_W-1:0] w_len_full;

    assign w_xfer       = in_valid && w_in_ready;
    assign w_start_load = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_count_inc  = r_load_count + 1'b1;
    assign w_sum_next   = r_sum + CSUM_W'(in_byte);
    assign w_len_full   = {r_len[ADDR_W-1:DATA_W], in_byte};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = LEN_HI;
            LEN_HI:  if (w_xfer) w_next_state = (in_byte[DATA_W-1:HI_W] != '0) ? ERR : LEN_LO;
            LEN_LO:  if (w_xfer) w_next_state = (w_len_full == '0) ? ERR : DATA;
            DATA:    if (w_xfer && w_count_inc == r_len) w_next_state = CSUM;
            CSUM:    if (w_xfer) w_next_state = (w_sum_next == '0) ? DONE : ERR;
            DONE:    if (start) w_next_state = LEN_HI;
            ERR:     if (start) w_next_state = LEN_HI;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_we       = 1'b0;
        case (r_state)
            LEN_HI, LEN_LO, CSUM: w_in_ready = 1'b1;
            DATA: begin
                w_in_ready = 1'b1;
                w_we       = in_valid;
            end
            default: ;
        endcase
    end

    // Status flags follow the next state so they change on the same edge as the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len        <= '0;
            r_load_count <= '0;
            r_sum        <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_cpu_reset <= (w_next_state != DONE);
            r_busy      <= (w_next_state == LEN_HI) || (w_next_state == LEN_LO) ||
                           (w_next_state == DATA)   || (w_next_state == CSUM);
            r_done      <= (w_next_state == DONE);
            r_error     <= (w_next_state == ERR);
            if (w_start_load) begin
                r_len        <= '0;
                r_load_count <= '0;
                r_sum        <= '0;
            end else if (w_xfer) begin
                case (r_state)
                    LEN_HI: r_len[ADDR_W-1:DATA_W] <= in_byte[HI_W-1:0];
                    LEN_LO: r_len[DATA_W-1:0]      <= in_byte;
                    DATA: begin
                        r_load_count <= w_count_inc;
                        r_sum        <= w_sum_next;
                    end
                    default: ;
                endcase
            end
        end
    end

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (w_we),
        .waddr (r_load_count),
        .wdata (in_byte),
        .raddr (PC),
        .rdata (program_byte)
    );

    assign in_ready   = w_in_ready;
    assign cpu_reset  = r_cpu_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign load_count = r_load_count;

endmodule
